// File: rtl/fifo_arb_pkg.sv
// Definitions for the FIFO write-port arbiter.
package fifo_arb_pkg;

    localparam int unsigned NUM_REQ_DEFAULT   = 4;
    localparam int unsigned MAX_BURST_DEFAULT = 4;
    localparam int unsigned CNT_WIDTH_DEFAULT = 16;

    // Burst-hold states (HOLD is only reachable when burst hold is compiled in).
    typedef enum logic {
        StIdle = 1'b0,
        StHold = 1'b1
    } arb_state_e;

    // Increment v modulo n.
    function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
        return (v + 1 >= n) ? 0 : v + 1;
    endfunction

endpackage

// File: rtl/fifo_pkg.sv
// Shared FIFO datapath definitions.
package fifo_pkg;

    // Width of one FIFO word.
    localparam int unsigned DATA_WIDTH = 8;

endpackage

// File: rtl/rr_pick.sv
// Wrap-around priority search: first valid bit at or after rr_ptr, searching upward.
module rr_pick #(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  valid,
    input  logic [IW-1:0] rr_ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic [IW-1:0] pos;

    // Scan N positions starting at rr_ptr; the first valid one wins.
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        pos   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            pos = IW'((32'(rr_ptr) + i) % N);
            if (!any && valid[pos]) begin
                grant[pos] = 1'b1;
                idx        = pos;
                any        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between NUM_REQ requesters.
// Zero-latency grant path; per-requester saturating beat counters.
// Optional burst hold (owner keeps the grant up to MAX_BURST beats) is compiled in
// only when FIFO_ARB_BURST_EN is defined.
module fifo_wr_arbiter
    import fifo_pkg::*;
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ   = NUM_REQ_DEFAULT,
    parameter int unsigned MAX_BURST = MAX_BURST_DEFAULT,
    parameter int unsigned CNT_WIDTH = CNT_WIDTH_DEFAULT,
    localparam int unsigned ID_W     = $clog2(NUM_REQ)
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [NUM_REQ-1:0]                  req_valid,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  req_data,
    output logic [NUM_REQ-1:0]                  req_ready,
    input  logic                                fifo_full,
    output logic                                fifo_wr_en,
    output logic [DATA_WIDTH-1:0]               fifo_wr_data,
    input  logic                                cnt_clr,
    output logic [NUM_REQ-1:0][CNT_WIDTH-1:0]   beat_cnt,
    output logic [ID_W-1:0]                     last_id,
    output logic                                busy
);

    if (NUM_REQ < 2 || NUM_REQ > 8 || MAX_BURST < 1 || MAX_BURST > 16) begin : g_bad_param
        $error("fifo_wr_arbiter: NUM_REQ must be 2..8 and MAX_BURST 1..16");
    end

    logic [ID_W-1:0]              rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]              last_id_q;
    logic [NUM_REQ-1:0][CNT_WIDTH-1:0] beat_cnt_q;

    logic [NUM_REQ-1:0]           pick_valid;
    logic [NUM_REQ-1:0]           grant;
    logic [ID_W-1:0]              win_idx;
    logic                         win_any;
    logic                         accept;

`ifdef FIFO_ARB_BURST_EN
    arb_state_e                   state_q, state_d;
    logic [ID_W-1:0]              owner_q, owner_d;
    logic [4:0]                   burst_q, burst_d;
    logic                         owner_valid;

    // While holding, only the owner may be picked.
    always_comb begin
        owner_valid = req_valid[owner_q];
        pick_valid  = req_valid;
        if (state_q == StHold) begin
            pick_valid = req_valid & (NUM_REQ'(1) << owner_q);
        end
    end
`else
    // Without burst hold every requester competes every cycle.
    always_comb begin
        pick_valid = req_valid;
    end
`endif

    rr_pick #(
        .N  (NUM_REQ),
        .IW (ID_W)
    ) u_rr_pick (
        .valid  (pick_valid),
        .rr_ptr (rr_ptr_q),
        .grant  (grant),
        .idx    (win_idx),
        .any    (win_any)
    );

    // Grant path: combinational, suppressed by a full FIFO or an asserted reset.
    always_comb begin
        accept       = rst_n & ~fifo_full & win_any;
        req_ready    = grant & {NUM_REQ{accept}};
        fifo_wr_en   = accept;
        fifo_wr_data = req_data[win_idx];
    end

`ifdef FIFO_ARB_BURST_EN
    // Burst FSM next state; a full FIFO freezes pointer, state and burst count.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        burst_d  = burst_q;
        rr_ptr_d = rr_ptr_q;
        if (!fifo_full) begin
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        if (MAX_BURST > 1) begin
                            state_d = StHold;
                            owner_d = win_idx;
                            burst_d = 5'd1;
                        end else begin
                            rr_ptr_d = ID_W'(wrap_inc(32'(win_idx), NUM_REQ));
                        end
                    end
                end
                StHold: begin
                    if (owner_valid && (32'(burst_q) + 1 < MAX_BURST)) begin
                        burst_d = burst_q + 5'd1;
                    end else begin
                        // Burst complete, or owner dropped valid (one bubble cycle).
                        state_d  = StIdle;
                        burst_d  = '0;
                        rr_ptr_d = ID_W'(wrap_inc(32'(owner_q), NUM_REQ));
                    end
                end
                default: state_d = StIdle;
            endcase
        end
        busy = (state_q == StHold);
    end

    // Burst FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            owner_q <= '0;
            burst_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            burst_q <= burst_d;
        end
    end
`else
    // Single-state round robin: pointer moves past each accepted requester.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (accept) begin
            rr_ptr_d = ID_W'(wrap_inc(32'(win_idx), NUM_REQ));
        end
        busy = 1'b0;
    end
`endif

    // Round-robin pointer and last accepted requester.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q  <= '0;
            last_id_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            if (accept) begin
                last_id_q <= win_idx;
            end
        end
    end

    // Saturating per-requester beat counters; clear wins over increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt_q <= '0;
        end else begin
            for (int unsigned k = 0; k < NUM_REQ; k++) begin
                if (cnt_clr) begin
                    beat_cnt_q[k] <= '0;
                end else if (req_ready[k] && (beat_cnt_q[k] != '1)) begin
                    beat_cnt_q[k] <= beat_cnt_q[k] + CNT_WIDTH'(1);
                end
            end
        end
    end

    assign beat_cnt = beat_cnt_q;
    assign last_id  = last_id_q;

endmodule
